// File: rtl/irq_ctrl.sv
// External interrupt controller ahead of CP0: latches edge/level sources into PEND,
// presents the lowest-index eligible source on irq/irq_id and holds it in service until ERET.
module irq_ctrl #(
  parameter int unsigned N_SRC = 8,
  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             irq_take,
  input  logic             irq_done,
  output logic             irq,
  output logic [IW-1:0]    irq_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] isr_q, isr_d;
  logic [N_SRC-1:0] src_prev_q;
  logic             irq_q, irq_d;
  logic [IW-1:0]    irq_id_q, irq_id_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] take_clr;
  logic [N_SRC-1:0] id_onehot;
  logic [N_SRC-1:0] rd_sel;
  logic             win_found;
  logic [IW-1:0]    win_id;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  always_comb begin
    rise    = src_in & ~src_prev_q;
    elig    = pend_q & mask_q;
    w1c_clr = '0;
    if (cfg_we && (cfg_addr == 2'd2)) begin
      w1c_clr = cfg_wdata[N_SRC-1:0];
    end
    id_onehot           = '0;
    id_onehot[irq_id_q] = 1'b1;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (elig[i] && !win_found) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
  end

  // Take beats withdrawal: the take branch is tested first in REQ.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    isr_d    = isr_q;
    take_clr = '0;
    unique case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (win_found) begin
          irq_id_d = win_id;
          irq_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (irq_take) begin
          isr_d    = id_onehot;
          take_clr = id_onehot;
          irq_d    = 1'b0;
          state_d  = SERVICE;
        end else if (!(pend_q[irq_id_q] && mask_q[irq_id_q])) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          isr_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Edge bits: set wins over W1C/take clear. Level bits simply track the line.
  always_comb begin
    pend_d = (edge_q & ((pend_q & ~(w1c_clr | take_clr)) | rise)) | (~edge_q & src_in);
    mask_d = mask_q;
    edge_d = edge_q;
    if (cfg_we && (cfg_addr == 2'd0)) mask_d = cfg_wdata[N_SRC-1:0];
    if (cfg_we && (cfg_addr == 2'd1)) edge_d = cfg_wdata[N_SRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      isr_q      <= '0;
      src_prev_q <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      isr_q      <= isr_d;
      src_prev_q <= src_in;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
    end
  end

  always_comb begin
    unique case (cfg_addr)
      2'd0:    rd_sel = mask_q;
      2'd1:    rd_sel = edge_q;
      2'd2:    rd_sel = pend_q;
      default: rd_sel = isr_q;
    endcase
    cfg_rdata              = '0;
    cfg_rdata[N_SRC-1:0]   = rd_sel;
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus a randomized run against a cycle reference model.
module tb_irq_ctrl;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  src_in = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          irq_take = 1'b0;
  logic          irq_done = 1'b0;
  logic          irq;
  logic [IW-1:0] irq_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_in   (src_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .irq_take (irq_take),
    .irq_done (irq_done),
    .irq      (irq),
    .irq_id   (irq_id)
  );

  // Reference model: phase 0 = waiting, 1 = requesting, 2 = in service.
  bit [N-1:0] m_mask, m_edge, m_pend, m_isr, m_prev;
  int         m_phase = 0;
  int         m_id = 0;

  function automatic int lowest(bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit [N-1:0] m_reg(int a);
    case (a)
      0: return m_mask;
      1: return m_edge;
      2: return m_pend;
      default: return m_isr;
    endcase
  endfunction

  task automatic model_step();
    bit [N-1:0] clr, pend_n, mask_n, edge_n, isr_n;
    int phase_n, id_n, w;
    if (rst) begin
      m_mask = '0; m_edge = '0; m_pend = '0; m_isr = '0; m_prev = '0;
      m_phase = 0; m_id = 0;
      return;
    end
    mask_n = m_mask; edge_n = m_edge; isr_n = m_isr; phase_n = m_phase; id_n = m_id;
    clr = '0;
    if (cfg_we && cfg_addr == 2'd2) clr = cfg_wdata[N-1:0];
    w = lowest(m_pend & m_mask);
    if (m_phase == 1 && irq_take) begin
      clr[m_id] = 1'b1; isr_n = '0; isr_n[m_id] = 1'b1; phase_n = 2;
    end else if (m_phase == 1 && !(m_pend[m_id] && m_mask[m_id])) begin
      phase_n = 0;
    end else if (m_phase == 2 && irq_done) begin
      isr_n = '0; phase_n = 0;
    end else if (m_phase == 0 && w >= 0) begin
      id_n = w; phase_n = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) pend_n[i] = (src_in[i] && !m_prev[i]) || (m_pend[i] && !clr[i]);
      else           pend_n[i] = src_in[i];
    end
    if (cfg_we && cfg_addr == 2'd0) mask_n = cfg_wdata[N-1:0];
    if (cfg_we && cfg_addr == 2'd1) edge_n = cfg_wdata[N-1:0];
    m_mask = mask_n; m_edge = edge_n; m_pend = pend_n; m_isr = isr_n;
    m_prev = src_in; m_phase = phase_n; m_id = id_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    cfg_addr = a;
    #1;
    v = cfg_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", irq); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", a, v); end
    end
  endtask

  task automatic test_edge_basic();
    logic [31:0] v;
    wr(2'd0, 32'h01); wr(2'd1, 32'h01);
    src_in = 8'h01; tick(); src_in = '0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_lat1: irq got %0b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL edge_req: irq=%0b id=%0d want 1/0", irq, irq_id); end
    tick(); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_hold: irq got %0b want 1", irq); end
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_take_irq: got %0b want 0", irq); end
    rd(2'd2, v);
    checks++; if (v !== 32'h00) begin errors++; $display("FAIL edge_take_pend: got %h want 00", v); end
    rd(2'd3, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL edge_take_isr: got %h want 01", v); end
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    rd(2'd3, v);
    checks++; if (v !== 32'h00) begin errors++; $display("FAIL edge_done_isr: got %h want 00", v); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_done_irq: got %0b want 0", irq); end
  endtask

  task automatic test_priority();
    wr(2'd0, 32'hFF); wr(2'd1, 32'hFF);
    src_in = 8'h24; tick(); src_in = '0; tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL prio_first: irq=%0b id=%0d want 1/2", irq, irq_id); end
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_gap: irq got %0b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd5) begin errors++; $display("FAIL prio_second: irq=%0b id=%0d want 1/5", irq, irq_id); end
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
  endtask

  task automatic test_level();
    wr(2'd1, 32'h00); wr(2'd0, 32'h08);
    src_in = 8'h08; tick(); tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL level_req: irq=%0b id=%0d want 1/3", irq, irq_id); end
    src_in = '0; tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_drop_lat: irq got %0b want 1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_withdraw: irq got %0b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_idle: irq got %0b want 0", irq); end
  endtask

  task automatic test_mask_withdraw();
    logic [31:0] v;
    wr(2'd1, 32'hFF); wr(2'd0, 32'h10);
    src_in = 8'h10; tick(); src_in = '0; tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd4) begin errors++; $display("FAIL mask_req: irq=%0b id=%0d want 1/4", irq, irq_id); end
    wr(2'd0, 32'h00); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_drop: irq got %0b want 0", irq); end
    rd(2'd2, v);
    checks++; if (v !== 32'h10) begin errors++; $display("FAIL mask_pend: got %h want 10", v); end
    wr(2'd0, 32'h10); tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd4) begin errors++; $display("FAIL mask_reassert: irq=%0b id=%0d want 1/4", irq, irq_id); end
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    wr(2'd0, 32'h00);
    src_in = 8'h02; wr(2'd2, 32'h02); src_in = '0;
    rd(2'd2, v);
    checks++; if (v !== 32'h02) begin errors++; $display("FAIL w1c_setwins: got %h want 02", v); end
    wr(2'd2, 32'h02);
    rd(2'd2, v);
    checks++; if (v !== 32'h00) begin errors++; $display("FAIL w1c_clear: got %h want 00", v); end
    wr(2'd3, 32'hFF);
    rd(2'd3, v);
    checks++; if (v !== 32'h00) begin errors++; $display("FAIL isr_ro: got %h want 00", v); end
  endtask

  task automatic test_reset_service();
    logic [31:0] v;
    wr(2'd0, 32'hFF);
    src_in = 8'h30; tick(); src_in = '0; tick();
    irq_take = 1'b1; tick(); irq_take = 1'b0;
    src_in = 8'h10; tick(); src_in = '0; tick();
    rd(2'd2, v);
    checks++; if (v !== 32'h30) begin errors++; $display("FAIL rsvc_pend: got %h want 30", v); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (irq !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL rsvc_out: irq=%0b id=%0d want 0/0", irq, irq_id); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rsvc_reg%0d: got %h want 0", a, v); end
    end
    irq_done = 1'b1; tick(); irq_done = 1'b0; tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rsvc_done_irq: got %0b want 0", irq); end
    rd(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rsvc_done_isr: got %h want 0", v); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      src_in    = N'($urandom & $urandom & $urandom);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      irq_take  = ($urandom_range(0, 2) == 0);
      irq_done  = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (irq !== (m_phase == 1)) begin errors++; $display("FAIL rand_irq c%0d: got %0b want %0b", c, irq, (m_phase == 1)); end
      checks++; if (irq_id !== IW'(m_id)) begin errors++; $display("FAIL rand_id c%0d: got %0d want %0d", c, irq_id, m_id); end
      checks++; if (cfg_rdata !== 32'(m_reg(int'(cfg_addr)))) begin errors++; $display("FAIL rand_rdata c%0d a%0d: got %h want %h", c, cfg_addr, cfg_rdata, m_reg(int'(cfg_addr))); end
    end
    rst = 1'b0; src_in = '0; cfg_we = 1'b0; irq_take = 1'b0; irq_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_level();
    test_mask_withdraw();
    test_w1c();
    test_reset_service();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
